// File: rtl/patgen_pkg.sv
// Shared types and default constants for the pattern row generator.
package patgen_pkg;

    // Row update rule selected at frame start
    typedef enum logic {
        MODE_LFSR   = 1'b0,
        MODE_RULE90 = 1'b1
    } mode_e;

    // Frame sequencing state
    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

    // Common maximal-length tap masks
    localparam logic [7:0]  TAPS_8  = 8'hB8;
    localparam logic [15:0] TAPS_16 = 16'hB400;

endpackage : patgen_pkg

// File: rtl/patgen_next_row.sv
// Combinational next-row function: Fibonacci LFSR step or rule-90 CA step.
module patgen_next_row
    import patgen_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_8)
) (
    input  logic [WIDTH-1:0] row,
    input  mode_e            mode,
    output logic [WIDTH-1:0] next_c
);

    // Zero-padded copy gives the null boundary cells r[-1] and r[WIDTH]
    logic [WIDTH+1:0] padded;
    assign padded = {1'b0, row, 1'b0};

    // Select the update rule for the current row
    always_comb begin
        next_c = '0;
        case (mode)
            MODE_LFSR: begin
                next_c = {row[WIDTH-2:0], ^(row & TAPS)};
            end
            MODE_RULE90: begin
                for (int i = 0; i < int'(WIDTH); i++) begin
                    next_c[i] = padded[i] ^ padded[i+2];
                end
            end
            default: begin
                next_c = row;
            end
        endcase
    end

endmodule : patgen_next_row

// File: rtl/pattern_row_gen.sv
// Frame-based row generator over a valid/ready stream.
// Optional build macro: PATGEN_LOCKUP_RECOVER_EN (replace a zero LFSR seed with 1).
module pattern_row_gen
    import patgen_pkg::*;
#(
    parameter int unsigned      WIDTH = 8,
    parameter logic [WIDTH-1:0] TAPS  = WIDTH'(TAPS_8),
    parameter logic [WIDTH-1:0] SEED  = WIDTH'(8'h01),
    parameter int unsigned      ROWS  = 8,
    localparam int unsigned     IDXW  = (ROWS > 1) ? $clog2(ROWS) : 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             mode_i,
    input  logic [WIDTH-1:0] seed_i,
    input  logic             seed_we_i,
    input  logic             start_i,
    output logic             busy_o,
    output logic [WIDTH-1:0] row_o,
    output logic             row_valid_o,
    input  logic             row_ready_i,
    output logic [IDXW-1:0]  row_idx_o,
    output logic             frame_last_o,
    output logic             lockup_o
);

    state_e           state_q, state_d;
    mode_e            mode_q;
    logic [WIDTH-1:0] seed_q;
    logic [WIDTH-1:0] row_q;
    logic [WIDTH-1:0] row_next;
    logic [WIDTH-1:0] seed_src;
    logic [WIDTH-1:0] load_val;
    logic [IDXW-1:0]  idx_q;
    logic             frame_last_q;
    logic             handshake;
    logic             idx_last;
    logic             load;
    logic             advance;
    logic             finish;

    assign handshake = (state_q == RUN) && row_ready_i;
    assign idx_last  = (idx_q == IDXW'(ROWS - 1));
    assign seed_src  = seed_we_i ? seed_i : seed_q;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start_i) state_d = RUN;
            RUN:     if (handshake && idx_last) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Datapath control decoded from the current state
    always_comb begin
        load    = 1'b0;
        advance = 1'b0;
        finish  = 1'b0;
        case (state_q)
            IDLE: begin
                load = start_i;
            end
            RUN: begin
                advance = handshake && !idx_last;
                finish  = handshake && idx_last;
            end
            default: begin
                load = 1'b0;
            end
        endcase
    end

`ifdef PATGEN_LOCKUP_RECOVER_EN
    logic lock_hit;
    logic lockup_q;

    assign lock_hit = (mode_e'(mode_i) == MODE_LFSR) && (seed_src == '0);
    assign load_val = lock_hit ? WIDTH'(1) : seed_src;

    // One-cycle pulse aligned with the first row of a recovered frame
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            lockup_q <= 1'b0;
        end else begin
            lockup_q <= load && lock_hit;
        end
    end

    assign lockup_o = lockup_q;
`else
    assign load_val = seed_src;
    assign lockup_o = 1'b0;
`endif

    // Seed register, writable in any state
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            seed_q <= SEED;
        end else if (seed_we_i) begin
            seed_q <= seed_i;
        end
    end

    // Row, index, mode and last-row flag; all held while the sink stalls
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q        <= SEED;
            idx_q        <= '0;
            mode_q       <= MODE_LFSR;
            frame_last_q <= 1'b0;
        end else if (load) begin
            row_q        <= load_val;
            idx_q        <= '0;
            mode_q       <= mode_e'(mode_i);
            frame_last_q <= (ROWS == 1);
        end else if (advance) begin
            row_q        <= row_next;
            idx_q        <= idx_q + 1'b1;
            frame_last_q <= ((idx_q + 1'b1) == IDXW'(ROWS - 1));
        end else if (finish) begin
            frame_last_q <= 1'b0;
        end
    end

    patgen_next_row #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS)
    ) u_next_row (
        .row    (row_q),
        .mode   (mode_q),
        .next_c (row_next)
    );

    assign busy_o       = (state_q == RUN);
    assign row_valid_o  = (state_q == RUN);
    assign row_o        = row_q;
    assign row_idx_o    = idx_q;
    assign frame_last_o = frame_last_q;

endmodule : pattern_row_gen

// File: tb/tb_pattern_row_gen.sv
// Self-checking bench for pattern_row_gen (WIDTH 8, TAPS B8, SEED 01, ROWS 8).
module tb_pattern_row_gen;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned ROWS  = 8;
    localparam logic [7:0]  TAPS  = 8'hB8;
    localparam logic [7:0]  SEED  = 8'h01;
`ifdef PATGEN_LOCKUP_RECOVER_EN
    localparam bit RECOVER = 1'b1;
`else
    localparam bit RECOVER = 1'b0;
`endif

    logic             clk = 1'b0;
    logic             rst;
    logic             mode_i;
    logic [WIDTH-1:0] seed_i;
    logic             seed_we_i;
    logic             start_i;
    logic             busy_o;
    logic [WIDTH-1:0] row_o;
    logic             row_valid_o;
    logic             row_ready_i;
    logic [2:0]       row_idx_o;
    logic             frame_last_o;
    logic             lockup_o;

    int checks = 0;
    int errors = 0;
    logic [7:0] model_seed;

    typedef struct {
        logic [7:0]  seed;
        logic        mode;
        bit          wr;
        bit          bypass;
        logic [31:0] exp;
    } vec_t;

    vec_t tbl [7];

    pattern_row_gen #(
        .WIDTH (WIDTH),
        .TAPS  (TAPS),
        .SEED  (SEED),
        .ROWS  (ROWS)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .mode_i       (mode_i),
        .seed_i       (seed_i),
        .seed_we_i    (seed_we_i),
        .start_i      (start_i),
        .busy_o       (busy_o),
        .row_o        (row_o),
        .row_valid_o  (row_valid_o),
        .row_ready_i  (row_ready_i),
        .row_idx_o    (row_idx_o),
        .frame_last_o (frame_last_o),
        .lockup_o     (lockup_o)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference next-row: shift plus tap parity, or neighbour XOR via shifts
    function automatic logic [7:0] model_next(input logic [7:0] r, input logic m);
        int ones;
        if (m) return 8'((r << 1) ^ (r >> 1));
        ones = 0;
        for (int i = 0; i < 8; i++) if (r[i] && TAPS[i]) ones++;
        return 8'(r << 1) | 8'(ones % 2);
    endfunction

    // Run one frame from IDLE and check every presented row
    task automatic run_frame(input logic [7:0] seed, input logic mode, input bit wr,
                             input bit bypass, input int ready_pct, input int stall_idx,
                             input bit has_exp, input logic [31:0] exp);
        logic [7:0] cur, src, last_row;
        bit lock, rdy;
        int j, cyc, stall, busy_cnt;
        if (wr) begin
            @(negedge clk);
            seed_i = seed; seed_we_i = 1'b1; model_seed = seed;
            @(negedge clk);
            seed_we_i = 1'b0; seed_i = 8'($urandom);
        end
        @(negedge clk);
        start_i = 1'b1; mode_i = mode;
        if (bypass) begin
            seed_i = seed; seed_we_i = 1'b1; model_seed = seed;
        end
        src  = bypass ? seed : model_seed;
        lock = RECOVER && (mode == 1'b0) && (src == 8'h00);
        cur  = lock ? 8'h01 : src;
        last_row = cur;
        @(negedge clk);
        start_i = 1'b0; seed_we_i = 1'b0;
        j = 0; cyc = 0; stall = 0; busy_cnt = 0;
        while (j < int'(ROWS) && cyc < 200) begin
            chk("valid", 32'(row_valid_o), 32'd1);
            chk("busy", 32'(busy_o), 32'd1);
            chk("row", 32'(row_o), 32'(cur));
            chk("idx", 32'(row_idx_o), 32'(j));
            chk("frame_last", 32'(frame_last_o), 32'(j == int'(ROWS) - 1));
            chk("lockup", 32'(lockup_o), 32'(lock && cyc == 0));
            if (has_exp && j < 4) chk("row_table", 32'(row_o), 32'(exp[31-8*j -: 8]));
            busy_cnt++;
            if (j == stall_idx && stall < 3) begin
                rdy = 1'b0; stall++;
            end else begin
                rdy = ($urandom_range(99) < 32'(ready_pct));
            end
            row_ready_i = rdy;
            start_i     = 1'($urandom);
            mode_i      = 1'($urandom);
            if ($urandom_range(7) == 0) begin
                seed_i = 8'($urandom); seed_we_i = 1'b1; model_seed = seed_i;
            end else begin
                seed_we_i = 1'b0;
            end
            @(negedge clk);
            cyc++;
            if (rdy) begin
                last_row = cur;
                cur = model_next(cur, mode);
                j++;
            end
        end
        start_i = 1'b0; seed_we_i = 1'b0; row_ready_i = 1'b0;
        if (j < int'(ROWS)) chk("frame_timeout", 32'(j), 32'(ROWS));
        chk("end_valid", 32'(row_valid_o), 32'd0);
        chk("end_busy", 32'(busy_o), 32'd0);
        chk("end_last", 32'(frame_last_o), 32'd0);
        chk("end_row_hold", 32'(row_o), 32'(last_row));
        if (ready_pct >= 100 && stall_idx < 0) chk("busy_cycles", 32'(busy_cnt), 32'(ROWS));
        if (stall_idx >= 0) chk("stall_count", 32'(stall), 32'd3);
    endtask

    initial begin
        int n;
        bit ok;
        tbl[0] = '{8'h01, 1'b0, 1'b0, 1'b0, 32'h01020408};
        tbl[1] = '{8'h10, 1'b1, 1'b0, 1'b1, 32'h102844AA};
        tbl[2] = '{8'h01, 1'b1, 1'b1, 1'b0, 32'h01020508};
        tbl[3] = '{8'h80, 1'b1, 1'b1, 1'b0, 32'h8040A010};
        tbl[4] = '{8'hFF, 1'b0, 1'b0, 1'b1, 32'hFFFEFCF8};
        tbl[5] = '{8'h00, 1'b0, 1'b1, 1'b0, RECOVER ? 32'h01020408 : 32'h00000000};
        tbl[6] = '{8'h00, 1'b1, 1'b0, 1'b1, 32'h00000000};

        rst = 1'b1; mode_i = 1'b0; seed_i = '0; seed_we_i = 1'b0;
        start_i = 1'b0; row_ready_i = 1'b0;
        model_seed = SEED;
        repeat (3) @(negedge clk);
        chk("rst_valid", 32'(row_valid_o), 32'd0);
        chk("rst_busy", 32'(busy_o), 32'd0);
        chk("rst_row", 32'(row_o), 32'(SEED));
        chk("rst_idx", 32'(row_idx_o), 32'd0);
        chk("rst_last", 32'(frame_last_o), 32'd0);
        chk("rst_lockup", 32'(lockup_o), 32'd0);
        rst = 1'b0;

        // Table vectors, ready held high
        for (int k = 0; k < 7; k++) begin
            run_frame(tbl[k].seed, tbl[k].mode, tbl[k].wr, tbl[k].bypass, 100, -1, 1'b1, tbl[k].exp);
        end

        // Back-pressure on row 2
        run_frame(8'h01, 1'b0, 1'b1, 1'b0, 100, 2, 1'b1, 32'h01020408);

        // Reset mid-frame at idx 3
        @(negedge clk);
        start_i = 1'b1; mode_i = 1'b1; seed_i = 8'h10; seed_we_i = 1'b1;
        @(negedge clk);
        start_i = 1'b0; seed_we_i = 1'b0; row_ready_i = 1'b1;
        ok = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (row_idx_o == 3'd3) begin ok = 1'b1; break; end
            @(negedge clk);
        end
        chk("reach_idx3", 32'(ok), 32'd1);
        row_ready_i = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("mid_rst_valid", 32'(row_valid_o), 32'd0);
        chk("mid_rst_busy", 32'(busy_o), 32'd0);
        chk("mid_rst_row", 32'(row_o), 32'(SEED));
        chk("mid_rst_idx", 32'(row_idx_o), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        model_seed = SEED;
        run_frame(8'h01, 1'b0, 1'b0, 1'b0, 100, -1, 1'b1, 32'h01020408);

        // Randomized frames against the reference model
        for (int k = 0; k < 40; k++) begin
            n = int'($urandom_range(7)) - 1;
            run_frame(($urandom_range(4) == 0) ? 8'h00 : 8'($urandom), 1'($urandom),
                      1'($urandom), 1'($urandom), int'($urandom_range(100, 40)),
                      (n >= 0 && n < 5) ? n : -1, 1'b0, 32'h0);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule : tb_pattern_row_gen
